noc_port_requester: RTL and testbench
=====================================

Name: noc_port_requester

Overview:
- Per-input-port requester for the 5-port NoC router. It is the requesting side of the router's req/grant/timer protocol.
- Buffers incoming flits in a small FIFO. When a header flit is at the FIFO head, it drives req, flit_id and length toward the arbiter.
- While granted, it streams the packet one flit per cycle. On tail it releases req so the arbiter can rotate.
- One instance sits in front of each arbiter request input (L, N, E, W, S).

Parameters:
- DATA_W, 16, flit payload width; must be >= LEN_W.
- LEN_W, 12, width of length field and length output.
- DEPTH, 4, FIFO depth in flits; power of two, >= 2.
- SLACK, 2, cycles added to flit count to form the arbiter timeout length.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  upstream flit valid
- in_ready  output  1  FIFO not full; push occurs when in_valid && in_ready
- in_flit_id  input  3  001 header, 010 body, 100 tail, others illegal
- in_data  input  DATA_W  flit payload; header carries packet flit count N in [LEN_W-1:0]
- req  output  1  request to arbiter
- flit_id  output  3  flit id of head flit while requesting/sending, else 000
- length  output  LEN_W  N+SLACK, latched from header
- grant  input  1  this port's bit of arbiter registered state
- out_valid  output  1  flit transferred to crossbar this cycle
- out_data  output  DATA_W  transferred flit payload
- err  output  1  sticky protocol error

Behaviour:
- Reset: FIFO empty, in_ready=1, req=0, flit_id=000, length=0, out_valid=0, out_data=0, err=0, state IDLE. rst mid-packet discards FIFO contents and the partial packet; req drops the next cycle.
- FIFO: synchronous push and pop. Push and pop in the same cycle leaves the count unchanged. When full, in_ready=0 and pushes are ignored. Pointers wrap modulo DEPTH.
- State IDLE: leaves IDLE when the FIFO is non-empty.
  - Head is a header → latch length = N+SLACK (truncated to LEN_W) and cnt=0, go REQUEST.
  - Head is not a header → pop it and discard, set err.
- State REQUEST: req=1, flit_id=001.
  - Go SEND when grant=1.
  - N=0 or N=1 in header → set err, pop header, return IDLE.
- State SEND: each cycle with grant=1 and FIFO non-empty:
  - pop one flit; out_valid=1; out_data=head (registered, 1-cycle latency from pop);
  - cnt++;
  - flit_id=head id.
- SEND, grant=1 and FIFO empty: stall. out_valid=0, req stays 1.
- SEND end of packet: on popping a tail, req=0 from the next cycle, go IDLE.
  - Tail popped with cnt+1 != N → err.
  - Non-tail popped at cnt+1 == N → err, force IDLE; remaining flits are discarded as non-headers.
- Header seen mid-packet: set err and treat it as a tail boundary. Do not pop it; go IDLE.
- State HOLD: entered from SEND when grant=0 mid-packet (arbiter timeout or preemption).
  - req=1, flit_id=010, no pops.
  - Return to SEND on grant=1.
  - Only headers reload the arbiter timer; the length is not re-presented.
- Consecutive packets: a minimum of one IDLE cycle with req=0 between packets.
- err: clears only on rst.

Decomposition:
- Shared package noc_pkg:
  - flit id constants FLIT_IDLE=000, FLIT_HEAD=001, FLIT_BODY=010, FLIT_TAIL=100;
  - LEN_W;
  - state enum {IDLE, REQUEST, SEND, HOLD}.
- Sub-module: noc_flit_fifo (parameterised DATA_W+3 wide, DEPTH deep, full/empty/count).

Test Plan:
- Reset → in_ready=1, req=0, flit_id=000, length=0, out_valid=0, err=0.
- Push header(N=3), body, tail; grant rises 2 cycles after req → req=1, length=5, flit_id=001 until grant. Three out_valid cycles with ids 001, 010, 100. req=0 the cycle after tail; err=0.
- Same packet, grant drops after the first flit for 3 cycles → HOLD: req stays 1, out_valid=0, flit_id=010. Resume on grant; all 3 flits delivered exactly once, in order.
- Push 5 flits with DEPTH=4 and no grant → in_ready=0 after 4; the 5th push is ignored; the FIFO contents are intact after grant.
- Header N=4 followed by body, tail → tail at cnt+1=3 sets err=1; block returns to IDLE; err persists until rst.
- Assert rst mid-SEND → next cycle req=0, FIFO empty, in_ready=1. The next header pushed is requested normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC router port logic: flit ids, default widths,
// and the requester state encoding.
// Latency: n/a (definitions only). Backpressure: n/a.
package noc_pkg;

  // Flit id encodings, one-hot for legal ids.
  localparam logic [2:0] FLIT_IDLE = 3'b000;
  localparam logic [2:0] FLIT_HEAD = 3'b001;
  localparam logic [2:0] FLIT_BODY = 3'b010;
  localparam logic [2:0] FLIT_TAIL = 3'b100;

  // Default width of the packet length field carried by a header flit.
  localparam int NOC_LEN_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SEND    = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/noc_port_requester_if.sv
// Bundle between one router input port, its arbiter request line and the crossbar.
// Latency: n/a (wires only). Backpressure: in_valid/in_ready on the upstream side.
// Ports: upstream in_valid/in_ready/in_flit_id/in_data; arbiter req/flit_id/length/grant;
//        crossbar out_valid/out_data; sticky err. slave = requester, master = its environment.
interface noc_port_requester_if #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_flit_id;
  logic [DATA_W-1:0] in_data;
  logic              req;
  logic [2:0]        flit_id;
  logic [LEN_W-1:0]  length;
  logic              grant;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              err;

  modport slave (
    input  in_valid, in_flit_id, in_data, grant,
    output in_ready, req, flit_id, length, out_valid, out_data, err
  );

  modport master (
    output in_valid, in_flit_id, in_data, grant,
    input  in_ready, req, flit_id, length, out_valid, out_data, err
  );
endinterface

// File: rtl/noc_flit_fifo.sv
// Small show-ahead flit FIFO; head is valid combinationally whenever not empty.
// Latency: a pushed flit is visible at head the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
// Ports: clk, rst (sync, active-high), push/push_data, pop, head, full, empty, count.
module noc_flit_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the count MSB is set exactly when full.
  assign full  = cnt[AW];
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) wide, so they wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; empty/full come from the counter alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/noc_port_requester.sv
// Per-input-port requester: buffers flits, requests the arbiter on a header, streams while granted.
// Latency: header visible at FIFO head -> req next cycle; pop -> out_valid/out_data next cycle.
// Backpressure: in_ready low when the FIFO is full; grant low mid-packet parks in HOLD with no pops.
// Ports: clk, rst (sync, active-high), bus (noc_port_requester_if.slave).
module noc_port_requester
  import noc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LEN_W  = NOC_LEN_W,
  parameter int DEPTH  = 4,
  parameter int SLACK  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  noc_port_requester_if.slave  bus
);
  localparam int FW = DATA_W + 3;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [FW-1:0]     fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              fifo_pop;

  logic [2:0]        head_id;
  logic [DATA_W-1:0] head_data;
  logic [LEN_W-1:0]  head_n;

  state_t            state;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  pkt_n;
  logic [LEN_W-1:0]  cnt_next;
  logic              req_q;
  logic [2:0]        flit_id_q;
  logic [LEN_W-1:0]  length_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              err_q;

  logic              short_pkt;
  logic              mid_hdr;
  logic              last_flit;

  noc_flit_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.in_valid),
    .push_data ({bus.in_flit_id, bus.in_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assert property (@(posedge clk) disable iff (rst) fifo_empty == (fifo_count == '0));

  assign head_id   = fifo_head[FW-1 -: 3];
  assign head_data = fifo_head[DATA_W-1:0];
  assign head_n    = head_data[LEN_W-1:0];

  // A packet needs at least a header and a tail.
  assign short_pkt = (pkt_n < LEN_W'(2));
  // The packet's own header is popped at cnt==0; any later header starts a new packet.
  assign mid_hdr   = (head_id == FLIT_HEAD) && (cnt != '0);
  assign cnt_next  = cnt + LEN_W'(1);
  assign last_flit = (cnt_next == pkt_n);

  // Pop decision mirrors the FSM branches below that consume the head flit.
  always_comb begin
    fifo_pop = 1'b0;
    case (state)
      IDLE:    fifo_pop = !fifo_empty && (head_id != FLIT_HEAD);
      REQUEST: fifo_pop = short_pkt;
      SEND:    fifo_pop = bus.grant && !fifo_empty && !mid_hdr;
      default: fifo_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pkt_n       <= '0;
      req_q       <= 1'b0;
      flit_id_q   <= FLIT_IDLE;
      length_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          req_q     <= 1'b0;
          flit_id_q <= FLIT_IDLE;
          if (!fifo_empty) begin
            if (head_id == FLIT_HEAD) begin
              length_q  <= head_n + LEN_W'(SLACK);
              pkt_n     <= head_n;
              cnt       <= '0;
              req_q     <= 1'b1;
              flit_id_q <= FLIT_HEAD;
              state     <= REQUEST;
            end else begin
              // Stray body/tail/illegal flit: dropped by the pop above.
              err_q <= 1'b1;
            end
          end
        end

        REQUEST: begin
          if (short_pkt) begin
            err_q     <= 1'b1;
            req_q     <= 1'b0;
            flit_id_q <= FLIT_IDLE;
            state     <= IDLE;
          end else if (bus.grant) begin
            state <= SEND;
          end
        end

        SEND: begin
          if (!bus.grant) begin
            flit_id_q <= FLIT_BODY;
            state     <= HOLD;
          end else if (!fifo_empty) begin
            if (mid_hdr) begin
              // Truncated packet: leave the new header in place for IDLE to pick up.
              err_q     <= 1'b1;
              req_q     <= 1'b0;
              flit_id_q <= FLIT_IDLE;
              state     <= IDLE;
            end else begin
              out_valid_q <= 1'b1;
              out_data_q  <= head_data;
              flit_id_q   <= head_id;
              cnt         <= cnt_next;
              if (head_id == FLIT_TAIL) begin
                req_q <= 1'b0;
                state <= IDLE;
                if (!last_flit) err_q <= 1'b1;
              end else if (last_flit) begin
                // Count exhausted without a tail; leftovers drain as stray flits.
                err_q <= 1'b1;
                req_q <= 1'b0;
                state <= IDLE;
              end
            end
          end
        end

        HOLD: begin
          if (bus.grant) state <= SEND;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.req       = req_q;
  assign bus.flit_id   = flit_id_q;
  assign bus.length    = length_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_noc_port_requester.sv
// Self-checking bench for noc_port_requester: vector table plus directed corner sequences.
// Latency: n/a. Backpressure: exercised via FIFO-full and grant withdrawal.
module tb_noc_port_requester;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  noc_port_requester_if #(.DATA_W(16), .LEN_W(12)) bus ();

  noc_port_requester #(
    .DATA_W (16),
    .LEN_W  (12),
    .DEPTH  (4),
    .SLACK  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        r;
    logic        vld;
    logic [2:0]  id;
    logic [15:0] dat;
    logic        gnt;
    logic        e_rdy;
    logic        e_req;
    logic [2:0]  e_fid;
    logic [11:0] e_len;
    logic        e_ov;
    logic [15:0] e_dat;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  logic [2:0]  rx_id  [16];
  logic [15:0] rx_dat [16];
  logic        rx_err [16];
  int          rx_n;

  function automatic vec_t mk(logic r, logic v, logic [2:0] id, logic [15:0] d, logic g,
                              logic rdy, logic rq, logic [2:0] fid, logic [11:0] len,
                              logic ov, logic [15:0] od, logic er);
    vec_t t;
    t.r = r; t.vld = v; t.id = id; t.dat = d; t.gnt = g;
    t.e_rdy = rdy; t.e_req = rq; t.e_fid = fid; t.e_len = len;
    t.e_ov = ov; t.e_dat = od; t.e_err = er;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] id, input logic [15:0] d);
    bus.in_valid   = 1'b1;
    bus.in_flit_id = id;
    bus.in_data    = d;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // Capture up to n delivered flits within a cycle budget.
  task automatic collect(input int n, input int budget);
    rx_n = 0;
    for (int c = 0; c < budget && rx_n < n; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        rx_id[rx_n]  = bus.flit_id;
        rx_dat[rx_n] = bus.out_data;
        rx_err[rx_n] = bus.err;
        rx_n++;
      end
    end
  endtask

  initial begin
    logic [2:0]  exp_id  [4];
    logic [15:0] exp_dat [4];

    bus.in_valid   = 1'b0;
    bus.in_flit_id = FLIT_IDLE;
    bus.in_data    = '0;
    bus.grant      = 1'b0;

    //        rst vld id         dat      gnt | rdy req fid        len ov  odat     err
    vecs.push_back(mk(1, 0, FLIT_IDLE, 16'h0000, 0,  1, 0, FLIT_IDLE, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, FLIT_HEAD, 16'h0003, 0,  1, 0, FLIT_IDLE, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, FLIT_BODY, 16'hB0B1, 0,  1, 1, FLIT_HEAD, 5, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, FLIT_TAIL, 16'h7A11, 0,  1, 1, FLIT_HEAD, 5, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, FLIT_IDLE, 16'h0000, 1,  1, 1, FLIT_HEAD, 5, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, FLIT_IDLE, 16'h0000, 1,  1, 1, FLIT_HEAD, 5, 1, 16'h0003, 0));
    vecs.push_back(mk(0, 0, FLIT_IDLE, 16'h0000, 1,  1, 1, FLIT_BODY, 5, 1, 16'hB0B1, 0));
    vecs.push_back(mk(0, 0, FLIT_IDLE, 16'h0000, 1,  1, 0, FLIT_TAIL, 5, 1, 16'h7A11, 0));
    // Second packet with the grant withdrawn for three cycles after the header.
    vecs.push_back(mk(0, 1, FLIT_HEAD, 16'h0003, 0,  1, 0, FLIT_IDLE, 5, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, FLIT_BODY, 16'h1111, 0,  1, 1, FLIT_HEAD, 5, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, FLIT_TAIL, 16'h2222, 1,  1, 1, FLIT_HEAD, 5, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, FLIT_IDLE, 16'h0000, 1,  1, 1, FLIT_HEAD, 5, 1, 16'h0003, 0));
    vecs.push_back(mk(0, 0, FLIT_IDLE, 16'h0000, 0,  1, 1, FLIT_BODY, 5, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, FLIT_IDLE, 16'h0000, 0,  1, 1, FLIT_BODY, 5, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, FLIT_IDLE, 16'h0000, 0,  1, 1, FLIT_BODY, 5, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, FLIT_IDLE, 16'h0000, 1,  1, 1, FLIT_BODY, 5, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, FLIT_IDLE, 16'h0000, 1,  1, 1, FLIT_BODY, 5, 1, 16'h1111, 0));
    vecs.push_back(mk(0, 0, FLIT_IDLE, 16'h0000, 1,  1, 0, FLIT_TAIL, 5, 1, 16'h2222, 0));
    vecs.push_back(mk(0, 0, FLIT_IDLE, 16'h0000, 0,  1, 0, FLIT_IDLE, 5, 0, 16'h0000, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst            = vecs[i].r;
      bus.in_valid   = vecs[i].vld;
      bus.in_flit_id = vecs[i].id;
      bus.in_data    = vecs[i].dat;
      bus.grant      = vecs[i].gnt;
      @(posedge clk); #1;
      chk($sformatf("v%0d.in_ready", i),  32'(bus.in_ready),  32'(vecs[i].e_rdy));
      chk($sformatf("v%0d.req", i),       32'(bus.req),       32'(vecs[i].e_req));
      chk($sformatf("v%0d.flit_id", i),   32'(bus.flit_id),   32'(vecs[i].e_fid));
      chk($sformatf("v%0d.length", i),    32'(bus.length),    32'(vecs[i].e_len));
      chk($sformatf("v%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d.err", i),       32'(bus.err),       32'(vecs[i].e_err));
      if (vecs[i].e_ov || vecs[i].r)
        chk($sformatf("v%0d.out_data", i), 32'(bus.out_data), 32'(vecs[i].e_dat));
    end
    bus.in_valid = 1'b0;
    bus.grant    = 1'b0;

    // FIFO full: four flits fill it, a fifth is refused and must not appear later.
    push(FLIT_HEAD, 16'h0004);
    push(FLIT_BODY, 16'h00A1);
    push(FLIT_BODY, 16'h00A2);
    push(FLIT_TAIL, 16'h00A3);
    chk("full.in_ready", 32'(bus.in_ready), 32'd0);
    push(FLIT_BODY, 16'h00FF);
    chk("full.in_ready_hold", 32'(bus.in_ready), 32'd0);
    chk("full.req", 32'(bus.req), 32'd1);
    chk("full.length", 32'(bus.length), 32'd6);
    exp_id[0] = FLIT_HEAD; exp_dat[0] = 16'h0004;
    exp_id[1] = FLIT_BODY; exp_dat[1] = 16'h00A1;
    exp_id[2] = FLIT_BODY; exp_dat[2] = 16'h00A2;
    exp_id[3] = FLIT_TAIL; exp_dat[3] = 16'h00A3;
    bus.grant = 1'b1;
    collect(4, 20);
    chk("full.rx_count", 32'(rx_n), 32'd4);
    for (int k = 0; k < rx_n && k < 4; k++) begin
      chk($sformatf("full.rx%0d.id", k), 32'(rx_id[k]), 32'(exp_id[k]));
      chk($sformatf("full.rx%0d.data", k), 32'(rx_dat[k]), 32'(exp_dat[k]));
    end
    bus.grant = 1'b0;
    cycles(3);
    chk("full.after.out_valid", 32'(bus.out_valid), 32'd0);
    chk("full.after.req", 32'(bus.req), 32'd0);
    chk("full.after.in_ready", 32'(bus.in_ready), 32'd1);
    chk("full.after.err", 32'(bus.err), 32'd0);

    // Length mismatch: header says 4 flits, tail arrives as the third.
    bus.grant = 1'b1;
    push(FLIT_HEAD, 16'h0004);
    push(FLIT_BODY, 16'h00B1);
    push(FLIT_TAIL, 16'h00B2);
    collect(3, 20);
    chk("len.rx_count", 32'(rx_n), 32'd3);
    chk("len.tail_id", 32'(rx_id[2]), 32'(FLIT_TAIL));
    chk("len.err_at_tail", 32'(rx_err[2]), 32'd1);
    chk("len.err_before_tail", 32'(rx_err[1]), 32'd0);
    cycles(2);
    chk("len.idle.req", 32'(bus.req), 32'd0);
    chk("len.idle.err", 32'(bus.err), 32'd1);
    push(FLIT_HEAD, 16'h0002);
    push(FLIT_TAIL, 16'h00C1);
    collect(2, 20);
    chk("len.next.rx_count", 32'(rx_n), 32'd2);
    chk("len.next.tail_data", 32'(rx_dat[1]), 32'h00C1);
    chk("len.next.length", 32'(bus.length), 32'd4);
    chk("len.next.err_sticky", 32'(bus.err), 32'd1);
    bus.grant = 1'b0;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("len.rst.err", 32'(bus.err), 32'd0);
    chk("len.rst.length", 32'(bus.length), 32'd0);
    chk("len.rst.flit_id", 32'(bus.flit_id), 32'(FLIT_IDLE));

    // Reset in the middle of SEND drops the packet; a later packet runs normally.
    bus.grant = 1'b1;
    push(FLIT_HEAD, 16'h0003);
    push(FLIT_BODY, 16'h00D1);
    collect(1, 20);
    chk("rst.first_flit", 32'(rx_n), 32'd1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    bus.grant = 1'b0;
    chk("rst.req", 32'(bus.req), 32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    cycles(3);
    chk("rst.quiet.req", 32'(bus.req), 32'd0);
    chk("rst.quiet.err", 32'(bus.err), 32'd0);
    bus.grant = 1'b1;
    push(FLIT_HEAD, 16'h0002);
    push(FLIT_TAIL, 16'h00E1);
    collect(2, 20);
    chk("rst.next.rx_count", 32'(rx_n), 32'd2);
    chk("rst.next.head_id", 32'(rx_id[0]), 32'(FLIT_HEAD));
    chk("rst.next.tail_id", 32'(rx_id[1]), 32'(FLIT_TAIL));
    chk("rst.next.tail_data", 32'(rx_dat[1]), 32'h00E1);
    chk("rst.next.length", 32'(bus.length), 32'd4);
    chk("rst.next.err", 32'(bus.err), 32'd0);
    bus.grant = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
